// File: rtl/tt_um_crc3_framer_if.sv
// Tiny Tapeout style pin bundle for the CRC-3 framer.
// The master side is the pad/stimulus side; the framer connects through the slave side.
interface tt_um_crc3_framer_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_crc3_framer.sv
// Frames a 5-bit message plus 3 zero flush slots onto the CRC-3 encoder's enable/bit pair,
// with a one-word holding register, sticky overflow and a wrapping completed-frame count.
module tt_um_crc3_framer (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  tt_um_crc3_framer_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e     state_q, state_d;
  logic [4:0] sr_q, sr_d;
  logic [2:0] slot_q, slot_d;
  logic [4:0] hold_q, hold_d;
  logic       pending_q, pending_d;
  logic       load_q, load_d;
  logic       overflow_q, overflow_d;
  logic [2:0] count_q, count_d;
  logic       tx_en_q, tx_en_d;
  logic       tx_bit_q, tx_bit_d;
  logic       busy_q, busy_d;

  logic [4:0] msg;
  logic       load, abort, load_pulse;
  logic       unused_bits;

  assign msg        = bus.ui_in[4:0];
  assign load       = bus.ui_in[5];
  assign abort      = bus.ui_in[6];
  assign load_pulse = load & ~load_q;
  assign unused_bits = ^{bus.uio_in, bus.ui_in[7]};

  always_comb begin
    logic       launch;
    logic [4:0] word;
    launch     = 1'b0;
    word       = 5'd0;
    state_d    = state_q;
    sr_d       = sr_q;
    slot_d     = slot_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    load_d     = load_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    tx_en_d    = tx_en_q;
    tx_bit_d   = tx_bit_q;

    if (ena) begin
      load_d = load;
      if (abort) begin
        state_d   = StIdle;
        tx_en_d   = 1'b0;
        tx_bit_d  = 1'b0;
        pending_d = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pending_q) begin
              launch    = 1'b1;
              word      = hold_q;
              pending_d = 1'b0;
              // A fresh load arriving as the held word launches refills the holder.
              if (load_pulse) begin
                hold_d    = msg;
                pending_d = 1'b1;
              end
            end else if (load_pulse) begin
              launch = 1'b1;
              word   = msg;
            end
          end
          StSend: begin
            if (load_pulse) begin
              if (!pending_q) begin
                hold_d    = msg;
                pending_d = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
            if (slot_q == 3'd7) begin
              state_d  = StIdle;
              tx_en_d  = 1'b0;
              tx_bit_d = 1'b0;
              count_d  = count_q + 3'd1;
            end else begin
              // Zeros shift in behind the data, so slots 5..7 emit the flush bits.
              slot_d   = slot_q + 3'd1;
              tx_bit_d = sr_q[3];
              sr_d     = {sr_q[3:0], 1'b0};
            end
          end
        endcase

        if (launch) begin
          state_d  = StSend;
          sr_d     = word;
          slot_d   = 3'd0;
          tx_en_d  = 1'b1;
          tx_bit_d = word[4];
        end
      end
    end

    busy_d = tx_en_d | pending_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sr_q       <= 5'd0;
      slot_q     <= 3'd0;
      hold_q     <= 5'd0;
      pending_q  <= 1'b0;
      load_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= 3'd0;
      tx_en_q    <= 1'b0;
      tx_bit_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      slot_q     <= slot_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      load_q     <= load_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      tx_en_q    <= tx_en_d;
      tx_bit_q   <= tx_bit_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.uo_out  = {count_q, overflow_q, pending_q, busy_q, tx_bit_q, tx_en_q};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_crc3_framer.sv
// Scoreboard bench for tt_um_crc3_framer: stimulus pushes expected slot bits, a monitor
// pops and compares on every cycle the framer drives tx_en.
module tb_tt_um_crc3_framer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  tt_um_crc3_framer_if bus ();

  tt_um_crc3_framer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [4:0] m);
    for (int i = 4; i >= 0; i--) exp_q.push_back(m[i]);
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ena        = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    #2;
    check("reset uo_out", bus.uo_out, 8'h00);
    check("reset uio_out", bus.uio_out, 8'h00);
    check("reset uio_oe", bus.uio_oe, 8'h00);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // High for one edge then low for one edge, so the next call is a fresh rising edge.
  task automatic pulse_load(input logic [4:0] m);
    bus.ui_in[4:0] = m;
    bus.ui_in[5]   = 1'b1;
    cyc();
    bus.ui_in[5]   = 1'b0;
    cyc();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.uo_out[2] && n < 100) begin
      cyc();
      n++;
    end
    check({name, " busy cleared"}, {7'd0, bus.uo_out[2]}, 8'h00);
  endtask

  task automatic check_drained(input string name);
    check({name, " queue drained"}, 8'(exp_q.size()), 8'h00);
  endtask

  // Monitor: a new slot appears after each enabled edge; a stalled edge repeats the last slot.
  initial begin
    bit ena_s;
    bit last_bit;
    bit have_last;
    have_last = 1'b0;
    forever begin
      @(posedge clk);
      ena_s = ena;
      @(negedge clk);
      if (bus.uo_out[0] === 1'b1) begin
        if (ena_s) begin
          if (exp_q.size() == 0) begin
            check("unexpected tx_en slot", 8'h01, 8'h00);
          end else begin
            last_bit  = exp_q.pop_front();
            have_last = 1'b1;
            check("tx_bit slot", {7'd0, bus.uo_out[1]}, {7'd0, last_bit});
          end
        end else if (have_last) begin
          check("tx_bit stalled slot", {7'd0, bus.uo_out[1]}, {7'd0, last_bit});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] wrap_msgs [7];
    wrap_msgs = '{5'b00001, 5'b10010, 5'b01100, 5'b11111, 5'b00000, 5'b10101, 5'b01010};
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // Single frame
    do_reset();
    push_frame(5'b10110);
    pulse_load(5'b10110);
    wait_idle("single");
    check("single tx_en low", {7'd0, bus.uo_out[0]}, 8'h00);
    check("single frame_count", {5'd0, bus.uo_out[7:5]}, 8'd1);
    check("single overflow", {7'd0, bus.uo_out[4]}, 8'h00);
    check_drained("single");

    // Back-to-back with one idle gap
    do_reset();
    push_frame(5'b10110);
    pulse_load(5'b10110);
    cyc();
    cyc();
    push_frame(5'b01011);
    pulse_load(5'b01011);
    check("b2b pending", {7'd0, bus.uo_out[3]}, 8'h01);
    check("b2b busy", {7'd0, bus.uo_out[2]}, 8'h01);
    for (int n = 0; n < 20 && bus.uo_out[0]; n++) cyc();
    check("b2b count after frame 1", {5'd0, bus.uo_out[7:5]}, 8'd1);
    cyc();
    check("b2b gap one cycle", {7'd0, bus.uo_out[0]}, 8'h01);
    check("b2b pending consumed", {7'd0, bus.uo_out[3]}, 8'h00);
    wait_idle("b2b");
    check("b2b frame_count", {5'd0, bus.uo_out[7:5]}, 8'd2);
    check_drained("b2b");

    // Overflow: second queued word wins, the rest are lost
    do_reset();
    push_frame(5'b11001);
    pulse_load(5'b11001);
    push_frame(5'b00001);
    pulse_load(5'b00001);
    check("ovf after first pulse", {7'd0, bus.uo_out[4]}, 8'h00);
    pulse_load(5'b00010);
    check("ovf after second pulse", {7'd0, bus.uo_out[4]}, 8'h01);
    pulse_load(5'b00100);
    wait_idle("ovf");
    check("ovf sticky", {7'd0, bus.uo_out[4]}, 8'h01);
    check("ovf frame_count", {5'd0, bus.uo_out[7:5]}, 8'd2);
    check_drained("ovf");

    // Abort with a pending word
    do_reset();
    push_frame(5'b11111);
    pulse_load(5'b11111);
    push_frame(5'b00110);
    pulse_load(5'b00110);
    check("abort pending before", {7'd0, bus.uo_out[3]}, 8'h01);
    bus.ui_in[6] = 1'b1;
    cyc();
    bus.ui_in[6] = 1'b0;
    exp_q.delete();
    check("abort tx_en", {7'd0, bus.uo_out[0]}, 8'h00);
    check("abort pending", {7'd0, bus.uo_out[3]}, 8'h00);
    check("abort frame_count", {5'd0, bus.uo_out[7:5]}, 8'd0);
    cyc();
    push_frame(5'b10000);
    pulse_load(5'b10000);
    wait_idle("post-abort");
    check("post-abort frame_count", {5'd0, bus.uo_out[7:5]}, 8'd1);
    check_drained("post-abort");

    // ena stall at slot 2, then frame_count wrap
    do_reset();
    push_frame(5'b01101);
    pulse_load(5'b01101);
    cyc();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall holds slot 2", bus.uo_out[1:0], 8'h03);
    end
    ena = 1'b1;
    wait_idle("stall");
    check("stall frame_count", {5'd0, bus.uo_out[7:5]}, 8'd1);
    for (int i = 0; i < 7; i++) begin
      push_frame(wrap_msgs[i]);
      pulse_load(wrap_msgs[i]);
      wait_idle("wrap");
      if (i == 5) check("wrap count 7", {5'd0, bus.uo_out[7:5]}, 8'd7);
    end
    check("wrap count 0", {5'd0, bus.uo_out[7:5]}, 8'd0);
    check_drained("wrap");

    // Asynchronous reset mid-frame
    do_reset();
    push_frame(5'b10101);
    pulse_load(5'b10101);
    cyc();
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset uo_out", bus.uo_out, 8'h00);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    cyc();
    push_frame(5'b00111);
    pulse_load(5'b00111);
    wait_idle("post-reset");
    check("post-reset frame_count", {5'd0, bus.uo_out[7:5]}, 8'd1);
    check("post-reset overflow", {7'd0, bus.uo_out[4]}, 8'h00);
    check_drained("post-reset");

    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_crc3_framer.md
# tt_um_crc3_framer

Upstream framing stage for the CRC-3 serial encoder. It accepts a 5-bit parallel message on a load strobe and buffers one further message in a holding register. It then drives the encoder's enable/serial-bit pair as an 8-slot frame: 5 data bits MSB-first, followed by 3 zero flush bits, so that the encoder emits `{msg, crc}` at frame end. The block also reports busy, pending, a sticky overflow flag and a completed-frame count.

## Interface
- No parameters. Frame length is fixed at 8 slots: 5 data slots plus 3 flush slots.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: platform enable. When low, all state holds.
- `ui_in` input 8:
  - `[4:0]` msg: message word, with bit 4 sent first.
  - `[5]` load: a load is recognised on a rising edge, i.e. sampled high at this edge and low at the previous edge.
  - `[6]` abort: active-high level.
  - `[7]` unused.
- `uo_out` output 8:
  - `[0]` tx_en: drives the encoder enable.
  - `[1]` tx_bit: drives the encoder serial bit.
  - `[2]` busy.
  - `[3]` pending.
  - `[4]` overflow.
  - `[7:5]` frame_count.
- `uio_in` input 8: unused.
- `uio_out` output 8: tied to 0.
- `uio_oe` output 8: tied to 0.

## Operation
- **State:**
  - FSM with states IDLE and SEND.
  - 5-bit shift register `sr`.
  - 3-bit slot counter.
  - 5-bit hold register with a pending flag.
  - `load_q` register for edge detection.
  - Sticky overflow flag.
  - 3-bit frame_count.
- **Outputs:**
  - All outputs are registered.
  - busy = tx_en OR pending.
- **IDLE:**
  - If pending is set: launch the hold word and clear pending.
  - Otherwise, if load_pulse: launch msg.
  - If pending launches and load_pulse occurs on the same edge, msg goes into hold and pending stays 1.
- **Launch** (at the edge of entering SEND):
  - `sr` <= word, slot <= 0.
  - tx_en <= 1, tx_bit <= word[4].
- **SEND:** each edge advances the slot.
  - Slots 1–4: tx_bit = `sr` bits 3..0 in turn.
  - Slots 5–7: tx_bit = 0 and tx_en = 1.
  - On the edge after slot 7: tx_en <= 0, tx_bit <= 0, state <= IDLE, frame_count <= frame_count + 1 (wraps 7 -> 0).
- **load_pulse during SEND** (including the frame-completing edge):
  - If pending = 0: hold <= msg, pending <= 1.
  - If pending = 1: the word is dropped and overflow <= 1; the hold contents are unchanged.
- **Inter-frame gap:** consecutive frames are always separated by exactly one cycle with tx_en = 0, which is the IDLE cycle.
- **abort** (sampled at the edge, priority over everything except reset and ena):
  - state <= IDLE, tx_en <= 0, tx_bit <= 0, pending <= 0.
  - A load_pulse on the same edge is ignored.
  - overflow and frame_count are unchanged; an aborted frame does not count.
  - load_q still updates.
- **ena = 0:** every register holds, including `load_q`. A load level change during ena = 0 is evaluated against the frozen `load_q` when ena returns.
- **overflow:** cleared only by reset.

## Timing
- **Reset:** async assert. All registers clear: uo_out = 8'h00, state IDLE, pending 0, `load_q` 0.
- **Latency:** load_pulse sampled at edge N gives tx_en = 1 from after edge N through the edge N+8 update.
  - Slot k is visible in the cycle following edge N+k.
  - tx_en falls at edge N+8.
  - frame_count updates at edge N+8.
- **Back-to-back:** a pending word launches at edge N+9, giving tx_en high again after N+9.
- **Throughput:** one frame per 9 cycles while pending is continuously refilled.
- **Stalls:** ena low stretches the frame with no slot skipped. Each slot stays visible for 1 + (stalled cycles) cycles.
- **Reset mid-frame:** tx_en drops immediately, with no completion and no count.

## Test plan
- **Single frame:** reset, then load msg = 5'b10110. Required response:
  - tx_bit = 1, 0, 1, 1, 0, 0, 0, 0 over 8 consecutive tx_en = 1 cycles.
  - Then tx_en = 0.
  - frame_count = 1, busy = 0, overflow = 0.
- **Back-to-back:** load 10110; at slot 3, load 01011. Required response:
  - pending = 1 and busy = 1.
  - After frame 1, exactly 1 cycle of tx_en = 0.
  - Then tx_bit = 0, 1, 0, 1, 1, 0, 0, 0.
  - frame_count = 2, pending = 0.
- **Overflow:** during a frame, issue three load pulses with 00001, 00010, 00100. Required response:
  - overflow = 1 after the second pulse and stays 1 through the next frames.
  - The second frame carries 00001 and the 00010/00100 words are lost.
  - No third frame; frame_count = 2.
- **Abort:** load 11111 and assert abort at slot 3 with pending = 1. Required response:
  - tx_en = 0 next cycle, pending = 0, frame_count unchanged at 0.
  - A following load of 10000 sends a full correct frame.
- **ena stall and frame_count wrap:**
  - Drop ena for 3 cycles at slot 2. Required response: slot 2 bit held for 4 cycles, remaining slots intact.
  - Run 8 frames. Required response: frame_count wraps to 0.
- **Async reset mid-frame:** pulse rst_n low at slot 4 between clock edges. Required response:
  - uo_out = 8'h00 immediately, without waiting for a clock edge.
  - After release, load 00111: a clean frame with frame_count = 1.
